// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed seven-segment driver fed by a packed BCD word.
// One cycle from index/held change to pins; never stalls upstream (no handshake).
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [15:0]   r_held;
  logic [3:0]    r_held_dp;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  logic          w_wrap;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_dec;
  logic [3:0]    w_an_hi;
  logic [6:0]    w_seg_hi;
  logic          w_dp_hi;

  assign w_wrap = (r_div == DW'(REFRESH_DIV - 1));

  always_comb begin
    w_digit = r_held[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_held[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_held[7:4];
        w_blank = blank_lz && (r_held[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit = r_held[11:8];
        w_blank = blank_lz && (r_held[15:8] == 8'd0);
      end
      default: begin
        w_digit = r_held[15:12];
        w_blank = blank_lz && (r_held[15:12] == 4'd0);
      end
    endcase
  end

  // Active-high {g,f,e,d,c,b,a}; codes above 9 render as a dash.
  always_comb begin
    w_dec = 7'b1000000;
    case (w_digit)
      4'd0: w_dec = 7'b0111111;
      4'd1: w_dec = 7'b0000110;
      4'd2: w_dec = 7'b1011011;
      4'd3: w_dec = 7'b1001111;
      4'd4: w_dec = 7'b1100110;
      4'd5: w_dec = 7'b1101101;
      4'd6: w_dec = 7'b1111101;
      4'd7: w_dec = 7'b0000111;
      4'd8: w_dec = 7'b1111111;
      4'd9: w_dec = 7'b1101111;
      default: w_dec = 7'b1000000;
    endcase
  end

  assign w_an_hi  = w_blank ? 4'd0 : (4'b0001 << r_idx);
  assign w_seg_hi = w_blank ? 7'd0 : w_dec;
  assign w_dp_hi  = w_blank ? 1'b0 : r_held_dp[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_idx     <= 2'd0;
      r_held    <= 16'd0;
      r_held_dp <= 4'd0;
      r_an      <= {4{ACTIVE_LOW}};
      r_seg     <= {7{ACTIVE_LOW}};
      r_dp      <= ACTIVE_LOW;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      if (load) begin
        r_held    <= bcd_in;
        r_held_dp <= dp_in;
      end
      r_an  <= w_an_hi ^ {4{ACTIVE_LOW}};
      r_seg <= w_seg_hi ^ {7{ACTIVE_LOW}};
      r_dp  <= w_dp_hi ^ ACTIVE_LOW;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner against a slot-arithmetic reference model.
module tb_seven_seg_scanner;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_held;
  logic [3:0]  m_hdp;
  int          m_n;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected pins come from edges-since-reset: slot = (edges / DIV) mod 4.
  task automatic tick();
    logic [6:0] s;
    logic       d;
    logic [3:0] a;
    int         k;
    if (rst) begin
      a = 4'hF; s = 7'h7F; d = 1'b1;
    end else begin
      k = (m_n / DIV) % 4;
      if (blank_lz && k > 0 && (m_held >> (4 * k)) == 16'd0) begin
        a = 4'hF; s = 7'h7F; d = 1'b1;
      end else begin
        a = ~(4'b0001 << k);
        s = ~seg_tab[m_held[4*k +: 4]];
        d = ~m_hdp[k];
      end
    end
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_held = 16'd0; m_hdp = 4'd0;
    end else begin
      m_n++;
      if (load) begin
        m_held = bcd_in;
        m_hdp  = dp_in;
      end
    end
    #1;
    check("an", 32'(an), 32'(a));
    check("seg", 32'(seg), 32'(s));
    check("dp", 32'(dp), 32'(d));
  endtask

  task automatic expect_pins(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    check({tag, "_an"}, 32'(an), 32'(a));
    check({tag, "_seg"}, 32'(seg), 32'(s));
    check({tag, "_dp"}, 32'(dp), 32'(d));
  endtask

  initial begin
    logic [3:0]  slot_an  [3];
    logic [6:0]  slot_seg [3];
    logic        slot_dp  [3];
    logic [15:0] w;

    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1000000;
    m_held = 16'd0; m_hdp = 4'd0; m_n = 0;

    // Reset dominates a concurrent load.
    rst = 1'b1; load = 1'b1; bcd_in = 16'h9999; dp_in = 4'hF; blank_lz = 1'b0;
    repeat (3) begin
      tick();
      expect_pins("reset", 4'b1111, 7'h7F, 1'b1);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    expect_pins("first", 4'b1110, 7'b1000000, 1'b1);

    // Plain scan of 1234 with dp on digit 2.
    rst = 1'b1; tick();
    rst = 1'b0; load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;
    tick();
    load = 1'b0;
    repeat (3) begin
      tick();
      expect_pins("scan0", 4'b1110, 7'b0011001, 1'b1);
    end
    slot_an[0] = 4'b1101; slot_seg[0] = 7'b0110000; slot_dp[0] = 1'b1;
    slot_an[1] = 4'b1011; slot_seg[1] = 7'b0100100; slot_dp[1] = 1'b0;
    slot_an[2] = 4'b0111; slot_seg[2] = 7'b1111001; slot_dp[2] = 1'b1;
    for (int sl = 0; sl < 3; sl++) begin
      repeat (DIV) begin
        tick();
        expect_pins("scan", slot_an[sl], slot_seg[sl], slot_dp[sl]);
      end
    end
    repeat (16) tick();

    // Leading-zero blanking, all-zero word and an invalid digit.
    blank_lz = 1'b1; load = 1'b1; bcd_in = 16'h0007; dp_in = 4'b1110;
    tick(); load = 1'b0;
    repeat (32) tick();
    load = 1'b1; bcd_in = 16'h0000; tick(); load = 1'b0;
    repeat (16) tick();
    load = 1'b1; bcd_in = 16'h0A05; dp_in = 4'b0000; tick(); load = 1'b0;
    repeat (20) tick();

    // Mid-slot load during digit 2, then mid-slot reset.
    for (int g = 0; g < 20 && !(((m_n / DIV) % 4) == 2 && (m_n % DIV) == 1); g++) tick();
    load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0000;
    tick(); load = 1'b0;
    tick();
    expect_pins("midload", 4'b1011, 7'b0000010, 1'b1);
    rst = 1'b1; tick();
    expect_pins("midrst", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0; tick();
    expect_pins("restart", 4'b1110, 7'b1000000, 1'b1);

    // Simultaneous rst and load must leave held at zero.
    rst = 1'b1; load = 1'b1; bcd_in = 16'h4321; tick();
    rst = 1'b0; load = 1'b0; tick();
    expect_pins("rstload", 4'b1110, 7'b1000000, 1'b1);

    // Random traffic: zero-heavy words, blank toggles, back-to-back loads, rare resets.
    for (int c = 0; c < 2000; c++) begin
      rst  = ($urandom_range(0, 149) == 0);
      load = ($urandom_range(0, 5) == 0) || (load && $urandom_range(0, 1) == 0);
      for (int d = 0; d < 4; d++) w[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bcd_in = w;
      dp_in  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
